uart_tx_fifo: RTL and testbench

- Transmit-side byte buffer between the PicoBlaze output port decode and the UART transmit engine inside the full UART.
- Absorbs bursts of processor writes and loads one byte at a time into the transmitter whenever the transmitter reports ready.
- Reports full/empty/level status for the UART status byte.
- Raises a one-cycle interrupt when the buffer drains.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_fifo_mem.sv | 32 +++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit-side FIFO.
//   - Default data/address widths for the byte buffer.
//   - Encodings of the transmit-load FSM states.
package uart_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD      = 2'b01,
        WAIT_BUSY = 2'b10
    } uart_tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: 2**AW x DW register file backing the transmit FIFO.
// Ports:
//   clk   - system clock, rising edge
//   we    - write enable, stores wdata at waddr on the clock edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
// Storage carries no reset; the FIFO pointers decide what is valid.
module uart_fifo_mem #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte buffer between the processor output port and
// the UART transmit engine. Buffers bursts of writes, hands one byte at a
// time to the transmitter, reports status and raises an interrupt on drain.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   wr_en     - one-cycle write strobe
//   wr_data   - byte to buffer
//   tx_rdy    - transmitter idle and able to accept a byte (level)
//   tx_load   - one-cycle load pulse to the transmitter
//   tx_data   - byte for the transmitter, held after tx_load
//   full      - occupancy equals depth
//   empty     - occupancy is zero
//   count     - occupancy, 0..2**AW
//   ovf       - sticky overflow (write while full)
//   clr_ovf   - one-cycle clear of ovf (a same-cycle overflow wins)
//   tx_int    - one-cycle pulse when a pop drains the FIFO
//   fsm_state - current load FSM state, for observation
//
// Transmitter handshake: the transmitter holds tx_rdy high while it can take
// a byte. A byte is popped only from IDLE with tx_rdy high; tx_load pulses
// the following cycle, and the FSM then waits for tx_rdy to drop (byte taken)
// before it may load again, so a lingering tx_rdy never double-loads.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          tx_rdy,
    output logic          tx_load,
    output logic [DW-1:0] tx_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          clr_ovf,
    output logic          tx_int,
    output logic [1:0]    fsm_state
);

    localparam int DEPTH = 1 << AW;

    uart_tx_state_t state, state_nxt;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] rd_byte;
    logic [AW:0]   count_nxt;
    logic          wr_accept;
    logic          pop;

    // Flags are registered, so a write into an empty FIFO cannot be popped in
    // the same cycle: there is no bypass path.
    assign wr_accept = wr_en && !full;
    assign pop       = (state == IDLE) && !empty && tx_rdy;

    uart_fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_byte)
    );

    always_comb begin
        count_nxt = count;
        if (wr_accept && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!wr_accept && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            tx_data <= '0;
            ovf     <= 1'b0;
            tx_int  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= rd_byte;
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH[AW:0]);
            empty <= (count_nxt == '0);
            // Overflow set takes priority over a same-cycle clear.
            if (wr_en && full) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            tx_int <= pop && !wr_accept && (count == (AW+1)'(1));
        end
    end

    // Load FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_load   = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                tx_load   = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          tx_rdy = 1'b0;
    logic          tx_load;
    logic [DW-1:0] tx_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          clr_ovf = 1'b0;
    logic          tx_int;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int int_cnt = 0;

    logic [DW-1:0] exp_q[$];

    uart_tx_fifo #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .tx_rdy    (tx_rdy),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf),
        .tx_int    (tx_int),
        .fsm_state (fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    // pulse counters, sampled 1 time unit after each edge
    always @(posedge clk) begin
        #1;
        if (tx_load === 1'b1) load_cnt++;
        if (tx_int === 1'b1) int_cnt++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step(1);
        wr_en   = 1'b0;
    endtask

    // Transmitter model: offer tx_rdy, take the byte on tx_load, then drop
    // tx_rdy long enough for the FIFO to return to IDLE.
    task automatic drain_one(input string name);
        logic [DW-1:0] exp_b;
        logic          seen;
        seen   = 1'b0;
        tx_rdy = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            if (tx_load === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: tx_load got 0 want 1 within 10 cycles", name);
        end else begin
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            if (tx_data !== exp_b) begin
                errors++;
                $display("FAIL %s data: got %h want %h", name, tx_data, exp_b);
            end
        end
        tx_rdy = 1'b0;
        step(2);
    endtask

    task automatic test_reset;
        checks++;
        if ({count, empty, full, tx_load, tx_data, ovf, tx_int} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b ld=%b d=%h ovf=%b int=%b want 0 1 0 0 00 0 0",
                     count, empty, full, tx_load, tx_data, ovf, tx_int);
        end
        rst = 1'b1;
        step(1);
        push(8'h6A);
        checks++;
        if (count !== 5'd1 || empty !== 1'b0 || tx_load !== 1'b0) begin
            errors++;
            $display("FAIL single_write: got cnt=%0d e=%b ld=%b want 1 0 0", count, empty, tx_load);
        end
        step(3);
        checks++;
        if (tx_load !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL hold_no_rdy: got ld=%b cnt=%0d want 0 1", tx_load, count);
        end
        tx_rdy = 1'b1;
        step(1);
        checks++;
        if (tx_load !== 1'b1 || tx_data !== 8'h6A || count !== 5'd0 || tx_int !== 1'b1) begin
            errors++;
            $display("FAIL first_load: got ld=%b d=%h cnt=%0d int=%b want 1 6a 0 1", tx_load, tx_data, count, tx_int);
        end
        step(1);
        checks++;
        if (tx_load !== 1'b0 || tx_int !== 1'b0 || tx_data !== 8'h6A) begin
            errors++;
            $display("FAIL pulse_width: got ld=%b int=%b d=%h want 0 0 6a", tx_load, tx_int, tx_data);
        end
        tx_rdy = 1'b0;
        step(2);
        checks++;
        if (load_cnt !== 1 || int_cnt !== 1) begin
            errors++;
            $display("FAIL pulse_count: got loads=%0d ints=%0d want 1 1", load_cnt, int_cnt);
        end
    endtask

    task automatic test_overflow;
        int ints0;
        ints0  = int_cnt;
        tx_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL fill16: got f=%b cnt=%0d ovf=%b want 1 16 0", full, count, ovf);
        end
        push(8'hFF);
        checks++;
        if (ovf !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_write: got ovf=%b cnt=%0d f=%b want 1 16 1", ovf, count, full);
        end
        // clear and new overflow in the same cycle: set wins
        clr_ovf = 1'b1;
        push(8'hFE);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_set_wins: got ovf=%b cnt=%0d want 1 16", ovf, count);
        end
        for (int i = 0; i < 16; i++) drain_one("drain_order");
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || int_cnt - ints0 !== 1) begin
            errors++;
            $display("FAIL drained: got cnt=%0d e=%b f=%b ints=%0d want 0 1 0 1", count, empty, full, int_cnt - ints0);
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", ovf);
        end
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_ovf: got %b want 0", ovf);
        end
    endtask

    task automatic test_wait_busy;
        int loads0;
        push(8'hA1);
        push(8'hA2);
        loads0 = load_cnt;
        tx_rdy = 1'b1;
        step(1);
        checks++;
        if (tx_load !== 1'b1 || tx_data !== 8'hA1) begin
            errors++;
            $display("FAIL wb_first: got ld=%b d=%h want 1 a1", tx_load, tx_data);
        end
        step(6);
        checks++;
        if (fsm_state !== WAIT_BUSY || load_cnt - loads0 !== 1 || count !== 5'd1) begin
            errors++;
            $display("FAIL wb_hold: got st=%0d loads=%0d cnt=%0d want 2 1 1", fsm_state, load_cnt - loads0, count);
        end
        tx_rdy = 1'b0;
        step(1);
        checks++;
        if (fsm_state !== IDLE || tx_load !== 1'b0) begin
            errors++;
            $display("FAIL wb_release: got st=%0d ld=%b want 0 0", fsm_state, tx_load);
        end
        tx_rdy = 1'b1;
        step(1);
        checks++;
        if (tx_load !== 1'b1 || tx_data !== 8'hA2 || count !== 5'd0) begin
            errors++;
            $display("FAIL wb_second: got ld=%b d=%h cnt=%0d want 1 a2 0", tx_load, tx_data, count);
        end
        tx_rdy = 1'b0;
        step(2);
    endtask

    task automatic test_no_bypass;
        tx_rdy = 1'b1;
        push(8'hC3);
        checks++;
        if (count !== 5'd1 || empty !== 1'b0 || tx_load !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: got cnt=%0d e=%b ld=%b want 1 0 0", count, empty, tx_load);
        end
        step(1);
        checks++;
        if (tx_load !== 1'b1 || tx_data !== 8'hC3 || count !== 5'd0 || tx_int !== 1'b1) begin
            errors++;
            $display("FAIL bypass_latency: got ld=%b d=%h cnt=%0d int=%b want 1 c3 0 1", tx_load, tx_data, count, tx_int);
        end
        tx_rdy = 1'b0;
        step(2);
    endtask

    task automatic test_full_pop_write;
        tx_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(8'hB0 + 8'(i));
            if (i > 0) exp_q.push_back(8'hB0 + 8'(i));
        end
        tx_rdy  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        step(1);
        wr_en   = 1'b0;
        tx_rdy  = 1'b0;
        checks++;
        if (count !== 5'd15 || ovf !== 1'b1 || full !== 1'b0 || tx_load !== 1'b1 || tx_data !== 8'hB0) begin
            errors++;
            $display("FAIL full_pop_write: got cnt=%0d ovf=%b f=%b ld=%b d=%h want 15 1 0 1 b0",
                     count, ovf, full, tx_load, tx_data);
        end
        step(2);
        for (int i = 0; i < 15; i++) drain_one("fpw_drain");
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL fpw_empty: got cnt=%0d e=%b want 0 1", count, empty);
        end
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
    endtask

    task automatic test_wrap;
        int lvl;
        int bad;
        lvl = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            push(8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
            lvl++;
            if (count !== 5'(lvl)) bad++;
            if (lvl == 3 || i == 39) begin
                while (lvl > 0) begin
                    drain_one("wrap_order");
                    lvl--;
                    if (count !== 5'(lvl)) bad++;
                end
            end
        end
        checks++;
        if (bad != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_count: got %0d count errors e=%b want 0 1", bad, empty);
        end
    endtask

    task automatic test_reset_in_load;
        int loads0;
        tx_rdy = 1'b0;
        push(8'hD1);
        push(8'hD2);
        tx_rdy = 1'b1;
        step(1);
        checks++;
        if (tx_load !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_load: got %b want 1", tx_load);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx_load !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || fsm_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset: got ld=%b cnt=%0d e=%b st=%0d want 0 0 1 0", tx_load, count, empty, fsm_state);
        end
        step(1);
        rst    = 1'b1;
        loads0 = load_cnt;
        step(6);
        checks++;
        if (load_cnt - loads0 !== 0 || count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL no_stale: got loads=%0d cnt=%0d e=%b want 0 0 1", load_cnt - loads0, count, empty);
        end
        tx_rdy = 1'b0;
        step(2);
    endtask

    initial begin
        step(2);
        test_reset();
        test_overflow();
        test_wait_busy();
        test_no_bypass();
        test_full_pop_write();
        test_wrap();
        test_reset_in_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global bound so a stuck run still ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
